// File: rtl/frame_buffer_dbl_if.sv
// Renderer/display-side bus of the double-buffered frame store.
//   master : renderer + display driver (drives writes, read address, requests)
//   slave  : frame_buffer_dbl (returns read data, ready and status)
// Signals:
//   wr_en/wr_addr/wr_data  back-bank pixel write, accepted while wr_ready=1
//   rd_addr/rd_data        front-bank read, data registered one cycle later
//   clear_req/fill_color   start a back-bank clear with the given colour
//   swap_req               exchange front and back banks
//   busy/clear_done/swap_done/front_sel  status
interface frame_buffer_dbl_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              clear_req;
  logic [DATA_W-1:0] fill_color;
  logic              swap_req;
  logic              busy;
  logic              clear_done;
  logic              swap_done;
  logic              front_sel;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, clear_req, fill_color, swap_req,
    input  wr_ready, rd_data, busy, clear_done, swap_done, front_sel
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, clear_req, fill_color, swap_req,
    output wr_ready, rd_data, busy, clear_done, swap_done, front_sel
  );
endinterface

// File: rtl/frame_buffer_dbl.sv
// Double-buffered pixel frame store. Two banks of DEPTH pixels live in one
// RAM: the back bank (!front_sel) takes renderer writes and clear-engine
// writes, the front bank (front_sel) is read every cycle by the display.
// Ports:
//   clk    sole clock, rising edge
//   rst_n  asynchronous active-low reset (control only, RAM content kept)
//   bus    frame_buffer_dbl_if slave modport, see interface header
module frame_buffer_dbl #(
  parameter int                ADDR_W     = 13,
  parameter int                DATA_W     = 16,
  parameter int                DEPTH      = 6144,
  parameter logic [DATA_W-1:0] INIT_COLOR = 16'hF81F
) (
  input logic               clk,
  input logic               rst_n,
  frame_buffer_dbl_if.slave bus
);

  localparam int IDX_W = $clog2(2 * DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    SWAP
  } state_t;

  state_t            state_q, state_d;
  logic              front_sel_q;
  logic              swap_pend_q;
  logic [ADDR_W-1:0] clr_addr_q;
  logic [DATA_W-1:0] fill_q;
  logic              clear_done_q;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_raw_q;

  logic              wr_in_range;
  logic              rd_in_range;
  logic              clr_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [IDX_W-1:0]  mem_widx;
  logic [IDX_W-1:0]  mem_ridx;

  // Bank 0 occupies words [0, DEPTH), bank 1 words [DEPTH, 2*DEPTH).
  function automatic logic [IDX_W-1:0] bank_index(input logic bank,
                                                   input logic [ADDR_W-1:0] addr);
    int unsigned base;
    base = bank ? DEPTH : 0;
    return IDX_W'(base + 32'(addr));
  endfunction

  // Both banks start out filled with INIT_COLOR at configuration time.
  logic [DATA_W-1:0] mem [2*DEPTH] = '{default: INIT_COLOR};

  assign wr_in_range = 32'(bus.wr_addr) < 32'(DEPTH);
  assign rd_in_range = 32'(bus.rd_addr) < 32'(DEPTH);
  assign clr_last    = (clr_addr_q == ADDR_W'(DEPTH - 1));

  // NOTE: every signal driven here gets a default first so no path through
  // the case leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d   = state_q;
    mem_we    = 1'b0;
    mem_waddr = bus.wr_addr;
    mem_wdata = bus.wr_data;
    unique case (state_q)
      IDLE: begin
        mem_we = bus.wr_en & wr_in_range;
        if (bus.clear_req)     state_d = CLEAR;
        else if (bus.swap_req) state_d = SWAP;
      end
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_addr_q;
        mem_wdata = fill_q;
        // A swap_req arriving on the final clear edge still counts as pending.
        if (clr_last) state_d = (swap_pend_q | bus.swap_req) ? SWAP : IDLE;
      end
      SWAP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_widx = bank_index(~front_sel_q, mem_waddr);
  // Out-of-range reads are masked to 0 below; park the RAM address at 0.
  assign mem_ridx = bank_index(front_sel_q, rd_in_range ? bus.rd_addr : '0);

  // NOTE: the RAM and its raw read register carry no reset so they map onto
  // block RAM; the zero-after-reset behaviour of rd_data comes from the
  // separately reset rd_valid_q qualifier.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_widx] <= mem_wdata;
    rd_raw_q <= mem[mem_ridx];
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // here sees the pre-edge values of the others, e.g. the bank swap and the
  // same-edge write both use the old front_sel_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      front_sel_q  <= 1'b0;
      swap_pend_q  <= 1'b0;
      clr_addr_q   <= '0;
      fill_q       <= '0;
      clear_done_q <= 1'b0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      clear_done_q <= (state_q == CLEAR) && clr_last;
      rd_valid_q   <= rd_in_range;
      if (state_d == SWAP && state_q != SWAP) front_sel_q <= ~front_sel_q;
      case (state_q)
        IDLE: begin
          if (bus.clear_req) begin
            clr_addr_q  <= '0;
            fill_q      <= bus.fill_color;
            swap_pend_q <= bus.swap_req;
          end
        end
        CLEAR: begin
          clr_addr_q <= clr_addr_q + 1'b1;
          if (bus.swap_req) swap_pend_q <= 1'b1;
        end
        SWAP:    swap_pend_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.rd_data    = rd_valid_q ? rd_raw_q : '0;
  assign bus.wr_ready   = (state_q == IDLE);
  assign bus.busy       = (state_q == CLEAR);
  assign bus.clear_done = clear_done_q;
  assign bus.swap_done  = (state_q == SWAP);
  assign bus.front_sel  = front_sel_q;

endmodule

// File: tb/tb_frame_buffer_dbl.sv
// Self-checking bench for frame_buffer_dbl with a small 16-pixel bank.
// A two-bank reference model tracks expected RAM content and front bank;
// read expectations are queued when a read address is driven and compared
// when the registered read data appears.
module tb_frame_buffer_dbl;

  localparam int          AW    = 5;
  localparam int          DW    = 16;
  localparam int          DEPTH = 16;
  localparam logic [15:0] INIT  = 16'hF81F;

  logic clk;
  logic rst_n;

  frame_buffer_dbl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  frame_buffer_dbl #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .DEPTH     (DEPTH),
    .INIT_COLOR(INIT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] mdl [2][DEPTH];
  logic        mfront;
  logic [15:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_px(input int addr, input string tag);
    logic [15:0] e;
    e = (addr < DEPTH) ? mdl[mfront][addr] : 16'h0000;
    exp_q.push_back(e);
    bus.rd_addr = AW'(addr);
    tick();
    e = exp_q.pop_front();
    check(tag, bus.rd_data, e);
  endtask

  task automatic write_px(input int addr, input logic [15:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(addr);
    bus.wr_data = data;
    if (addr < DEPTH) mdl[~mfront][addr] = data;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic swap_idle();
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    mfront = ~mfront;
    check("swap_done_hi", bus.swap_done, 1'b1);
    check("swap_front", bus.front_sel, mfront);
    tick();
    check("swap_done_lo", bus.swap_done, 1'b0);
  endtask

  // Full clear of the back bank; a write to addr 2 is held on throughout and
  // must be dropped. swap_at>0 pulses swap_req on that clear cycle.
  task automatic clear_run(input logic [15:0] color, input int swap_at);
    int n;
    bus.fill_color = color;
    bus.clear_req  = 1'b1;
    tick();
    bus.clear_req  = 1'b0;
    bus.fill_color = 16'h0000;
    bus.wr_en      = 1'b1;
    bus.wr_addr    = AW'(2);
    bus.wr_data    = 16'hFFFF;
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      n++;
      if (n == 1) check("wr_ready_clear", bus.wr_ready, 1'b0);
      check("front_hold", bus.front_sel, mfront);
      bus.swap_req = (n == swap_at);
      tick();
    end
    bus.wr_en    = 1'b0;
    bus.swap_req = 1'b0;
    check("busy_cycles", n, 16);
    check("clear_done_hi", bus.clear_done, 1'b1);
    for (int i = 0; i < DEPTH; i++) mdl[~mfront][i] = color;
    if (swap_at != 0) begin
      mfront = ~mfront;
      check("defer_swap_done", bus.swap_done, 1'b1);
      check("defer_front", bus.front_sel, mfront);
    end else begin
      check("no_swap_done", bus.swap_done, 1'b0);
    end
    tick();
    check("clear_done_lo", bus.clear_done, 1'b0);
    check("swap_done_after", bus.swap_done, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < DEPTH; i++) mdl[b][i] = INIT;
    mfront         = 1'b0;
    bus.wr_en      = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.rd_addr    = '0;
    bus.clear_req  = 1'b0;
    bus.fill_color = '0;
    bus.swap_req   = 1'b0;
    rst_n          = 1'b0;

    // Reset values
    #2;
    check("rst_front", bus.front_sel, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_rd_data", bus.rd_data, 16'h0000);
    check("rst_clear_done", bus.clear_done, 1'b0);
    check("rst_swap_done", bus.swap_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst_wr_ready", bus.wr_ready, 1'b1);
    read_px(0, "init_rd0");

    // Write to back bank, swap, read it back
    write_px(5, 16'h07E0);
    swap_idle();
    read_px(5, "rd_after_swap5");
    read_px(4, "rd_after_swap4");

    // Plain clear of bank 0, then swap and read every pixel
    clear_run(16'h001F, 0);
    swap_idle();
    for (int i = 0; i < DEPTH; i++) read_px(i, "clear_fill");

    // Clear with a swap request on the 3rd clear cycle
    clear_run(16'hA5A5, 3);
    read_px(0, "defer_rd0");
    read_px(5, "defer_rd5");
    read_px(15, "defer_rd15");

    // Out-of-range write and read
    write_px(DEPTH, 16'h1234);
    read_px(0, "oor_no_alias");
    read_px(DEPTH, "oor_rd_zero");

    // Reset during clear cycle 8 of 16
    bus.fill_color = 16'h0F0F;
    bus.clear_req  = 1'b1;
    tick();
    bus.clear_req  = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    #2;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_front", bus.front_sel, 1'b0);
    check("abort_rd_data", bus.rd_data, 16'h0000);
    check("abort_clear_done", bus.clear_done, 1'b0);
    check("abort_swap_done", bus.swap_done, 1'b0);
    for (int i = 0; i < 7; i++) mdl[~mfront][i] = 16'h0F0F;
    mfront = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("abort_no_done", bus.clear_done, 1'b0);
    check("abort_ready", bus.wr_ready, 1'b1);
    for (int i = 0; i < DEPTH; i++) read_px(i, "abort_content");

    // Write coinciding with swap_req lands in the pre-swap back bank
    bus.wr_en    = 1'b1;
    bus.wr_addr  = AW'(3);
    bus.wr_data  = 16'hBEEF;
    bus.swap_req = 1'b1;
    mdl[~mfront][3] = 16'hBEEF;
    tick();
    bus.wr_en    = 1'b0;
    bus.swap_req = 1'b0;
    mfront = ~mfront;
    check("wrswap_front", bus.front_sel, mfront);
    check("wrswap_done", bus.swap_done, 1'b1);
    tick();
    read_px(3, "wrswap_rd3");
    read_px(4, "wrswap_rd4");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
